instr_fetch_ctrl: RTL and testbench

Fetch sequencer and port arbiter for the single-port instruction BRAM (2048 x 32, one-cycle registered read). It owns the BRAM port and shares it between a boot-time program loader (writes) and the fetch stream (reads). It maintains the fetch PC, hides the one-cycle read latency behind a 2-entry output buffer, and delivers instructions to decode over a valid/ready handshake at one instruction per cycle. It sits between the BRAM instance and the decode stage of the RISC core.

---
 rtl/instr_fetch_ctrl_if.sv | 51 +++++
 rtl/instr_fetch_ctrl.sv | 141 ++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_ctrl_if.sv
// Bundle of the BRAM port, program-loader port and decode-side fetch port
// of the instruction fetch controller. The controller uses the master view.
interface instr_fetch_ctrl_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32
);
    // BRAM port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Program loader
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ack;

    // Fetch control and decode handshake
    logic              run;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              busy;

    modport master (
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        input  ld_req, ld_addr, ld_data,
        output ld_ack,
        input  run, redirect, redirect_pc,
        output instr, instr_pc, instr_valid,
        input  instr_ready,
        output busy
    );

    modport slave (
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        output ld_req, ld_addr, ld_data,
        input  ld_ack,
        output run, redirect, redirect_pc,
        input  instr, instr_pc, instr_valid,
        output instr_ready,
        input  busy
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer and BRAM port arbiter. Shares the single BRAM
// port between the boot loader (writes, IDLE only) and the fetch stream, and
// hides the one-cycle read latency behind a 2-entry {instr, pc} buffer.
module instr_fetch_ctrl #(
    parameter int unsigned       ADDR_W   = 11,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    instr_fetch_ctrl_if.master   io_bus
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    state_e            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_infl_pc;
    logic [1:0]        r_count, w_count_nxt;
    logic [DATA_W-1:0] r_buf_data [2];
    logic [DATA_W-1:0] w_buf_data_nxt [2];
    logic [ADDR_W-1:0] r_buf_pc [2];
    logic [ADDR_W-1:0] w_buf_pc_nxt [2];

    logic       w_ld_wr;
    logic       w_pop;
    logic       w_push;
    logic       w_flush;
    logic       w_issue;
    logic       w_push_idx;
    logic [1:0] w_occ;

    // Port arbitration, issue decision and buffer occupancy
    always_comb begin
        w_ld_wr = i_rst_n && (r_state == StIdle) && io_bus.ld_req;
        w_pop   = (r_count != 2'd0) && io_bus.instr_ready;
        w_flush = (r_state == StRun) && io_bus.redirect;
        w_push  = r_inflight && !w_flush;
        // Occupancy after this cycle's pop, counting the word still in the BRAM
        w_occ   = r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        w_issue = i_rst_n && (r_state == StRun) && io_bus.run && !io_bus.redirect
                  && (w_occ < 2'd2);
        // Tail slot once this cycle's pop has shifted the head out
        w_push_idx = (r_count == 2'd2) || ((r_count == 2'd1) && !w_pop);
    end

    // Next state and fetch PC
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        unique case (r_state)
            StIdle: begin
                if (io_bus.run && !io_bus.ld_req) begin
                    w_state_nxt = StRun;
                    w_pc_nxt    = RESET_PC;
                end
            end
            StRun: begin
                if (io_bus.redirect) begin
                    w_pc_nxt = io_bus.redirect_pc;
                end else if (!io_bus.run) begin
                    w_state_nxt = StDrain;
                end else if (w_issue) begin
                    w_pc_nxt = r_pc + ADDR_W'(1);
                end
            end
            StDrain: begin
                if (io_bus.run) begin
                    w_state_nxt = StRun;
                end else if ((r_count == 2'd0) && !r_inflight) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Buffer next state: pop shifts entry 1 to the head, push fills the tail
    always_comb begin
        w_buf_data_nxt = r_buf_data;
        w_buf_pc_nxt   = r_buf_pc;
        w_count_nxt    = r_count;
        if (w_flush) begin
            w_count_nxt = 2'd0;
        end else begin
            if (w_pop) begin
                w_buf_data_nxt[0] = r_buf_data[1];
                w_buf_pc_nxt[0]   = r_buf_pc[1];
            end
            if (w_push) begin
                w_buf_data_nxt[w_push_idx] = io_bus.mem_rdata;
                w_buf_pc_nxt[w_push_idx]   = r_infl_pc;
            end
            w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // State, PC, in-flight tracking and buffer registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_pc       <= RESET_PC;
            r_inflight <= 1'b0;
            r_infl_pc  <= '0;
            r_count    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_buf_data[i] <= '0;
                r_buf_pc[i]   <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_infl_pc <= r_pc;
            end
            r_count    <= w_count_nxt;
            r_buf_data <= w_buf_data_nxt;
            r_buf_pc   <= w_buf_pc_nxt;
        end
    end

    // Output drive; load and issue are both forced off while in reset
    always_comb begin
        io_bus.mem_en      = w_ld_wr || w_issue;
        io_bus.mem_we      = w_ld_wr;
        io_bus.mem_addr    = w_ld_wr ? io_bus.ld_addr : (w_issue ? r_pc : '0);
        io_bus.mem_wdata   = w_ld_wr ? io_bus.ld_data : '0;
        io_bus.ld_ack      = w_ld_wr;
        io_bus.instr       = r_buf_data[0];
        io_bus.instr_pc    = r_buf_pc[0];
        io_bus.instr_valid = (r_count != 2'd0);
        io_bus.busy        = (r_state != StIdle);
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: a BRAM model, directed scenarios
// and a randomized ready/redirect phase checked against an in-order stream model.
module tb_instr_fetch_ctrl;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 32;
    localparam int unsigned NW = 2048;

    logic clk;
    logic rst_n;
    logic preload;

    instr_fetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    instr_fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC('0)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference memory contents as the program image should look
    logic [DW-1:0] image [NW];
    // BRAM model: one-cycle registered read, write on enable+we
    logic [DW-1:0] bram [NW];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < NW; i++) bram[i] <= image[i];
        end else if (bus.mem_en) begin
            if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= bram[bus.mem_addr];
        end
    end

    int unsigned errors;
    int unsigned checks;
    logic [AW-1:0] exp_pc;   // next pc the decode stream should see
    int unsigned   accepted;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stream model: every accepted word must be the next sequential pc and
    // carry the program image word; a redirect restarts the sequence.
    task automatic adv();
        if (bus.redirect) begin
            exp_pc = bus.redirect_pc;
        end else if (bus.instr_valid && bus.instr_ready) begin
            chk("acc_pc", 64'(bus.instr_pc), 64'(exp_pc));
            chk("acc_data", 64'(bus.instr), 64'(image[exp_pc]));
            exp_pc = exp_pc + 1'b1;
            accepted++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_en"}, 64'(bus.mem_en), 64'd0);
        chk({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
        chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
        chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
        chk({tag, "_ld_ack"}, 64'(bus.ld_ack), 64'd0);
        chk({tag, "_instr"}, 64'(bus.instr), 64'd0);
        chk({tag, "_instr_pc"}, 64'(bus.instr_pc), 64'd0);
        chk({tag, "_valid"}, 64'(bus.instr_valid), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] prog [3];
        logic [AW-1:0] wrap_exp [4];
        logic [DW-1:0] h_instr;
        logic [AW-1:0] h_pc;
        logic [AW-1:0] drain_start;
        int unsigned   post_redir;
        int unsigned   n;

        prog[0] = 32'h0000_0013;
        prog[1] = 32'h0010_0093;
        prog[2] = 32'h0020_0113;
        wrap_exp[0] = 11'd2046;
        wrap_exp[1] = 11'd2047;
        wrap_exp[2] = 11'd0;
        wrap_exp[3] = 11'd1;

        errors = 0;
        checks = 0;
        exp_pc = '0;
        accepted = 0;
        for (int i = 0; i < NW; i++) image[i] = $urandom;

        // Reset with loader and run requests active: outputs must stay 0
        rst_n = 1'b0;
        preload = 1'b1;
        bus.ld_req = 1'b1;
        bus.ld_addr = 11'd7;
        bus.ld_data = 32'hffff_ffff;
        bus.run = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.instr_ready = 1'b1;
        bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Load three words with run also high: load wins, IDLE is held
        for (int k = 0; k < 3; k++) begin
            bus.ld_req = 1'b1;
            bus.ld_addr = AW'(k);
            bus.ld_data = prog[k];
            #1;
            chk("ld_ack", 64'(bus.ld_ack), 64'd1);
            chk("ld_we", 64'(bus.mem_we), 64'd1);
            chk("ld_en", 64'(bus.mem_en), 64'd1);
            chk("ld_addr", 64'(bus.mem_addr), 64'(k));
            chk("ld_wdata", 64'(bus.mem_wdata), 64'(prog[k]));
            chk("ld_busy", 64'(bus.busy), 64'd0);
            image[k] = prog[k];
            adv();
        end

        // Cycle N: ld_req drops, run sampled
        bus.ld_req = 1'b0;
        #1;
        chk("start_busy", 64'(bus.busy), 64'd0);
        chk("start_en", 64'(bus.mem_en), 64'd0);
        adv();
        // N+1: first issue; a loader request in RUN is ignored
        bus.ld_req = 1'b1;
        bus.ld_addr = 11'd5;
        bus.ld_data = 32'hdead_beef;
        #1;
        chk("run_busy", 64'(bus.busy), 64'd1);
        chk("run_ld_ack", 64'(bus.ld_ack), 64'd0);
        chk("run_ld_we", 64'(bus.mem_we), 64'd0);
        chk("first_issue_en", 64'(bus.mem_en), 64'd1);
        chk("first_issue_addr", 64'(bus.mem_addr), 64'd0);
        chk("first_valid_n1", 64'(bus.instr_valid), 64'd0);
        adv();
        bus.ld_req = 1'b0;
        #1;
        chk("first_valid_n2", 64'(bus.instr_valid), 64'd0);
        chk("second_issue_addr", 64'(bus.mem_addr), 64'd1);
        adv();
        #1;
        chk("first_valid_n3", 64'(bus.instr_valid), 64'd1);
        chk("first_instr", 64'(bus.instr), 64'h0000_0013);
        chk("first_pc", 64'(bus.instr_pc), 64'd0);
        adv();

        // Steady streaming: one instruction every cycle
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("steady_valid", 64'(bus.instr_valid), 64'd1);
            adv();
        end

        // Stall: head stable, no further reads once full
        bus.instr_ready = 1'b0;
        #1;
        h_instr = bus.instr;
        h_pc = bus.instr_pc;
        chk("stall_en", 64'(bus.mem_en), 64'd0);
        adv();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("stall_valid", 64'(bus.instr_valid), 64'd1);
            chk("stall_instr", 64'(bus.instr), 64'(h_instr));
            chk("stall_pc", 64'(bus.instr_pc), 64'(h_pc));
            chk("stall_en", 64'(bus.mem_en), 64'd0);
            adv();
        end
        // Release for a few cycles: sequence resumes without gaps
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            adv();
        end

        // Redirect with a full buffer
        bus.instr_ready = 1'b0;
        repeat (3) begin
            #1;
            adv();
        end
        bus.redirect = 1'b1;
        bus.redirect_pc = 11'h200;
        #1;
        chk("redir_no_issue", 64'(bus.mem_en), 64'd0);
        adv();
        bus.redirect = 1'b0;
        bus.instr_ready = 1'b1;
        #1;
        chk("redir_valid_n1", 64'(bus.instr_valid), 64'd0);
        chk("redir_issue_en", 64'(bus.mem_en), 64'd1);
        chk("redir_issue_addr", 64'(bus.mem_addr), 64'h200);
        adv();
        #1;
        chk("redir_valid_n2", 64'(bus.instr_valid), 64'd0);
        adv();
        #1;
        chk("redir_valid_n3", 64'(bus.instr_valid), 64'd1);
        chk("redir_pc0", 64'(bus.instr_pc), 64'h200);
        adv();
        #1;
        chk("redir_pc1", 64'(bus.instr_pc), 64'h201);
        adv();

        // Fetch across the top of the address space
        bus.redirect = 1'b1;
        bus.redirect_pc = 11'd2046;
        #1;
        adv();
        bus.redirect = 1'b0;
        repeat (2) begin
            #1;
            adv();
        end
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("wrap_valid", 64'(bus.instr_valid), 64'd1);
            chk("wrap_pc", 64'(bus.instr_pc), 64'(wrap_exp[k]));
            adv();
        end

        // Random ready and occasional redirects against the stream model
        post_redir = 0;
        for (int k = 0; k < 400; k++) begin
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            bus.redirect = (post_redir == 0) && ($urandom_range(0, 31) == 0);
            bus.redirect_pc = AW'($urandom);
            #1;
            if (post_redir > 0) chk("rand_redir_bubble", 64'(bus.instr_valid), 64'd0);
            post_redir = bus.redirect ? 2 : ((post_redir > 0) ? post_redir - 1 : 0);
            adv();
        end
        bus.redirect = 1'b0;
        bus.instr_ready = 1'b1;
        repeat (6) begin
            #1;
            adv();
        end

        // Drain: head and the in-flight word are delivered, then IDLE
        bus.run = 1'b0;
        #1;
        drain_start = exp_pc;
        chk("drain_no_issue", 64'(bus.mem_en), 64'd0);
        chk("drain_busy", 64'(bus.busy), 64'd1);
        adv();
        n = 0;
        while (n < 10) begin
            #1;
            if (!bus.busy) break;
            chk("drain_no_issue2", 64'(bus.mem_en), 64'd0);
            adv();
            n++;
        end
        chk("drain_idle", 64'(bus.busy), 64'd0);
        chk("drain_valid", 64'(bus.instr_valid), 64'd0);
        chk("drain_delivered", 64'(exp_pc), 64'(drain_start + 11'd2));
        adv();

        // Restart from IDLE fetches from RESET_PC again, then reset mid-RUN
        exp_pc = '0;
        bus.run = 1'b1;
        repeat (6) begin
            #1;
            adv();
        end
        #1;
        chk("pre_reset_valid", 64'(bus.instr_valid), 64'd1);
        rst_n = 1'b0;
        bus.ld_req = 1'b1;
        #1;
        chk_all_zero("midrun_reset");
        bus.ld_req = 1'b0;
        bus.run = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_reset_busy", 64'(bus.busy), 64'd0);
        chk("post_reset_valid", 64'(bus.instr_valid), 64'd0);
        adv();
        #1;
        chk("post_reset_idle", 64'(bus.busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
